stream_mux_rr: RTL and testbench

- Parametrised successor to the gate-level 2:1 mux: NUM_CH-input, WIDTH-bit registered stream multiplexer with valid/ready handshakes.
- Two modes: explicit select (sel port, like the 2:1 mux) and round-robin arbitration.
- One output register stage.
- Sits in the MIPS datapath/bus fabric wherever several producers (e.g. writeback sources, memory requesters) share one consumer.

---
 rtl/stream_mux_rr_if.sv | 27 ++
 rtl/stream_mux_rr.sv | 103 ++++++++++
 tb/tb_stream_mux_rr.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/stream_mux_rr_if.sv
// Stream bundle between NUM_CH producers and the shared consumer of stream_mux_rr.
// The slave modport is the mux's view; master is the producer/consumer side.
interface stream_mux_rr_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_CH = 4
);
  localparam int SEL_W = $clog2(NUM_CH);

  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH-1:0]       in_ready;
  logic [SEL_W-1:0]        sel;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic [SEL_W-1:0]        out_ch;
  logic                    out_ready;

  modport slave (
    input  in_data, in_valid, sel, out_ready,
    output in_ready, out_data, out_valid, out_ch
  );

  modport master (
    output in_data, in_valid, sel, out_ready,
    input  in_ready, out_data, out_valid, out_ch
  );
endinterface

// File: rtl/stream_mux_rr.sv
// NUM_CH-to-1 registered stream multiplexer with either sel-driven or
// round-robin channel choice and a single output register stage.
module stream_mux_rr #(
  parameter int WIDTH  = 32,
  parameter int NUM_CH = 4,
  parameter int MODE   = 0
) (
  input  logic           clk,
  input  logic           reset,
  stream_mux_rr_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_CH);

  logic [WIDTH-1:0]  outData_q, outData_d;
  logic [SEL_W-1:0]  outCh_q, outCh_d;
  logic              outValid_q, outValid_d;
  logic [SEL_W-1:0]  rrPtr_q, rrPtr_d;

  logic              canLoad;
  logic              grantValid;
  logic              transfer;
  logic [SEL_W-1:0]  grant;
  logic [WIDTH-1:0]  grantData;
  logic [NUM_CH-1:0] inReady;
  int                idx;

  // Round-robin scans from lowest to highest priority so the last hit wins.
  always_comb begin
    grant      = '0;
    grantValid = 1'b0;
    idx        = 0;
    if (MODE == 0) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.sel == SEL_W'(i)) begin
          grant      = SEL_W'(i);
          grantValid = bus.in_valid[i];
        end
      end
    end else begin
      for (int k = NUM_CH; k >= 1; k--) begin
        idx = int'(rrPtr_q) + k;
        if (idx >= NUM_CH) idx = idx - NUM_CH;
        for (int i = 0; i < NUM_CH; i++) begin
          if (idx == i && bus.in_valid[i]) begin
            grant      = SEL_W'(i);
            grantValid = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    grantData = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant == SEL_W'(i)) grantData = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  assign canLoad = !outValid_q || bus.out_ready;

  always_comb begin
    inReady = '0;
    for (int g = 0; g < NUM_CH; g++) begin
      inReady[g] = !reset && canLoad && grantValid && (grant == SEL_W'(g));
    end
  end

  assign transfer = |(inReady & bus.in_valid);

  // A drain without a new load clears valid but keeps the last data and channel.
  always_comb begin
    outData_d  = outData_q;
    outCh_d    = outCh_q;
    outValid_d = outValid_q && !bus.out_ready;
    rrPtr_d    = rrPtr_q;
    if (transfer) begin
      outData_d  = grantData;
      outCh_d    = grant;
      outValid_d = 1'b1;
      rrPtr_d    = grant;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      outData_q  <= '0;
      outCh_q    <= '0;
      outValid_q <= 1'b0;
      rrPtr_q    <= SEL_W'(NUM_CH - 1);
    end else begin
      outData_q  <= outData_d;
      outCh_q    <= outCh_d;
      outValid_q <= outValid_d;
      rrPtr_q    <= rrPtr_d;
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.out_data  = outData_q;
  assign bus.out_valid = outValid_q;
  assign bus.out_ch    = outCh_q;
endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: fixed-select 4ch, round-robin 4ch and
// fixed-select 3ch instances sharing one clock and reset.
module tb_stream_mux_rr;
  logic clk;
  logic reset;
  int   vectorCount = 0;
  int   missCount   = 0;

  stream_mux_rr_if #(.WIDTH(8), .NUM_CH(4)) ifA ();
  stream_mux_rr_if #(.WIDTH(8), .NUM_CH(4)) ifB ();
  stream_mux_rr_if #(.WIDTH(8), .NUM_CH(3)) ifC ();

  stream_mux_rr #(.WIDTH(8), .NUM_CH(4), .MODE(0)) dutA (.clk(clk), .reset(reset), .bus(ifA));
  stream_mux_rr #(.WIDTH(8), .NUM_CH(4), .MODE(1)) dutB (.clk(clk), .reset(reset), .bus(ifB));
  stream_mux_rr #(.WIDTH(8), .NUM_CH(3), .MODE(0)) dutC (.clk(clk), .reset(reset), .bus(ifC));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    reset         = 1'b1;
    ifA.in_data   = {8'hC3, 8'hA5, 8'h3C, 8'h5A};
    ifA.in_valid  = 4'b1111;
    ifA.sel       = 2'd0;
    ifA.out_ready = 1'b1;
    ifB.in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
    ifB.in_valid  = 4'b1111;
    ifB.sel       = 2'd0;
    ifB.out_ready = 1'b1;
    ifC.in_data   = {8'h33, 8'h22, 8'h11};
    ifC.in_valid  = 3'b111;
    ifC.sel       = 2'd0;
    ifC.out_ready = 1'b1;

    // Reset held with every channel valid
    applyStimulus(2);
    #1;
    checkOutput("rst_A_valid", 32'(ifA.out_valid), 32'h0);
    checkOutput("rst_A_data",  32'(ifA.out_data),  32'h0);
    checkOutput("rst_A_ready", 32'(ifA.in_ready),  32'h0);
    checkOutput("rst_B_valid", 32'(ifB.out_valid), 32'h0);
    checkOutput("rst_B_data",  32'(ifB.out_data),  32'h0);
    checkOutput("rst_B_ch",    32'(ifB.out_ch),    32'h0);
    checkOutput("rst_B_ready", 32'(ifB.in_ready),  32'h0);
    checkOutput("rst_C_ready", 32'(ifC.in_ready),  32'h0);

    // Round-robin with all channels valid: 0,1,2,3,0
    reset        = 1'b0;
    ifA.in_valid = 4'b0000;
    ifC.in_valid = 3'b000;
    #1;
    checkOutput("rr_first_ready", 32'(ifB.in_ready), 32'h1);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1);
      checkOutput($sformatf("rr_valid_%0d", k), 32'(ifB.out_valid), 32'h1);
      checkOutput($sformatf("rr_data_%0d", k),  32'(ifB.out_data),  32'h10 + 32'(k % 4));
      checkOutput($sformatf("rr_ch_%0d", k),    32'(ifB.out_ch),    32'(k % 4));
      checkOutput($sformatf("rr_ready_%0d", k), 32'(ifB.in_ready),  32'(1 << ((k + 1) % 4)));
    end

    // Backpressure holds beat 0x10 from ch0; ch1 stays the pending winner
    ifB.out_ready = 1'b0;
    #1;
    checkOutput("bp_ready_now", 32'(ifB.in_ready), 32'h0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1);
      checkOutput($sformatf("bp_data_%0d", k),  32'(ifB.out_data),  32'h10);
      checkOutput($sformatf("bp_ch_%0d", k),    32'(ifB.out_ch),    32'h0);
      checkOutput($sformatf("bp_valid_%0d", k), 32'(ifB.out_valid), 32'h1);
      checkOutput($sformatf("bp_ready_%0d", k), 32'(ifB.in_ready),  32'h0);
    end
    ifB.out_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready", 32'(ifB.in_ready), 32'h2);
    applyStimulus(1);
    checkOutput("bp_after_data",  32'(ifB.out_data), 32'h11);
    checkOutput("bp_after_ch",    32'(ifB.out_ch),   32'h1);
    checkOutput("bp_after_ready", 32'(ifB.in_ready), 32'h4);

    // Sparse channels 0 and 3: 3, then wrap to 0, then 3 again
    ifB.in_valid = 4'b1001;
    #1;
    checkOutput("sp_ready_3", 32'(ifB.in_ready), 32'h8);
    applyStimulus(1);
    checkOutput("sp_data_3",  32'(ifB.out_data), 32'h13);
    checkOutput("sp_ch_3",    32'(ifB.out_ch),   32'h3);
    checkOutput("sp_ready_0", 32'(ifB.in_ready), 32'h1);
    applyStimulus(1);
    checkOutput("sp_data_0",  32'(ifB.out_data), 32'h10);
    checkOutput("sp_ch_0",    32'(ifB.out_ch),   32'h0);
    checkOutput("sp_ready_w", 32'(ifB.in_ready), 32'h8);
    ifB.in_valid = 4'b0000;
    #1;
    checkOutput("sp_idle_ready", 32'(ifB.in_ready), 32'h0);
    applyStimulus(1);
    checkOutput("sp_drain_valid", 32'(ifB.out_valid), 32'h0);
    checkOutput("sp_drain_data",  32'(ifB.out_data),  32'h10);
    checkOutput("sp_drain_ch",    32'(ifB.out_ch),    32'h0);

    // Fixed select on the 4-channel mux
    ifA.sel      = 2'd2;
    ifA.in_valid = 4'b0100;
    #1;
    checkOutput("fs_ready_2", 32'(ifA.in_ready), 32'h4);
    applyStimulus(1);
    checkOutput("fs_data_2",  32'(ifA.out_data),  32'hA5);
    checkOutput("fs_ch_2",    32'(ifA.out_ch),    32'h2);
    checkOutput("fs_valid_2", 32'(ifA.out_valid), 32'h1);
    ifA.sel = 2'd3;
    #1;
    checkOutput("fs_ready_none", 32'(ifA.in_ready), 32'h0);
    applyStimulus(1);
    checkOutput("fs_valid_drop", 32'(ifA.out_valid), 32'h0);
    checkOutput("fs_data_hold",  32'(ifA.out_data),  32'hA5);
    ifA.in_valid = 4'b1000;
    #1;
    checkOutput("fs_ready_3", 32'(ifA.in_ready), 32'h8);
    applyStimulus(1);
    checkOutput("fs_data_3", 32'(ifA.out_data), 32'hC3);
    checkOutput("fs_ch_3",   32'(ifA.out_ch),   32'h3);
    ifA.in_valid = 4'b0000;

    // Three channels: out-of-range sel, then reset drops a stalled beat
    ifC.sel      = 2'd3;
    ifC.in_valid = 3'b111;
    #1;
    checkOutput("c3_ready_oor", 32'(ifC.in_ready), 32'h0);
    applyStimulus(1);
    checkOutput("c3_valid_oor", 32'(ifC.out_valid), 32'h0);
    ifC.sel       = 2'd2;
    ifC.out_ready = 1'b0;
    #1;
    checkOutput("c3_ready_2", 32'(ifC.in_ready), 32'h4);
    applyStimulus(1);
    checkOutput("c3_data_2",  32'(ifC.out_data),  32'h33);
    checkOutput("c3_valid_2", 32'(ifC.out_valid), 32'h1);
    checkOutput("c3_stall",   32'(ifC.in_ready),  32'h0);
    reset = 1'b1;
    applyStimulus(1);
    checkOutput("c3_rst_valid", 32'(ifC.out_valid), 32'h0);
    checkOutput("c3_rst_data",  32'(ifC.out_data),  32'h0);
    checkOutput("c3_rst_ch",    32'(ifC.out_ch),    32'h0);
    checkOutput("c3_rst_ready", 32'(ifC.in_ready),  32'h0);
    reset        = 1'b0;
    ifC.in_valid = 3'b000;
    applyStimulus(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end
endmodule
